// File: rtl/fas_serial_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
// The master side issues requests; the slave side is the sequencer itself.
interface fas_serial_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         a_ns_in;
    logic         cin_in;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a_in, b_in, a_ns_in, cin_in,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, a_in, b_in, a_ns_in, cin_in,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/fas_serial_ctrl.sv
// Bit-serial N-bit add/subtract sequencer around a single 1-bit fas cell,
// processing operands LSB-first with the carry/borrow held in a flop.
module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    // a_ns=1 gives the add carry, a_ns=0 gives the subtract borrow
    assign cout = a_ns ? ((a & b) | (a & cin) | (b & cin))
                       : ((~a & b) | (~a & cin) | (b & cin));
endmodule

module fas_serial_ctrl #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fas_serial_ctrl_if.slave     bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_reg;
    logic [N-1:0] a_sh_reg;
    logic [N-1:0] b_sh_reg;
    logic [N-1:0] res_reg;
    logic [CW-1:0] cnt_reg;
    logic         op_reg;
    logic         carry_reg;
    logic         a_msb_reg;
    logic         b_msb_reg;
    logic         busy_reg;
    logic         done_reg;
    logic         ovf_reg;

    logic         fas_s;
    logic         fas_cout;
    logic         ovf_next;

    fas u_fas (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .a_ns (op_reg),
        .s    (fas_s),
        .cout (fas_cout)
    );

    // Overflow is judged from the MSB the cell produces on the final RUN edge.
    always_comb begin
        ovf_next = 1'b0;
        if (op_reg) begin
            ovf_next = (a_msb_reg == b_msb_reg) && (fas_s != a_msb_reg);
        end else begin
            ovf_next = (a_msb_reg != b_msb_reg) && (fas_s != a_msb_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            op_reg    <= 1'b0;
            carry_reg <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    res_reg   <= {fas_s, res_reg[N-1:1]};
                    a_sh_reg  <= {1'b0, a_sh_reg[N-1:1]};
                    b_sh_reg  <= {1'b0, b_sh_reg[N-1:1]};
                    carry_reg <= fas_cout;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(N - 1)) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        ovf_reg   <= ovf_next;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; results persist otherwise
                    if (bus.start) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        a_sh_reg  <= bus.a_in;
                        b_sh_reg  <= bus.b_in;
                        op_reg    <= bus.a_ns_in;
                        carry_reg <= bus.cin_in;
                        cnt_reg   <= '0;
                        res_reg   <= '0;
                        a_msb_reg <= bus.a_in[N-1];
                        b_msb_reg <= bus.b_in[N-1];
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = res_reg;
    assign bus.cout   = carry_reg;
    assign bus.ovf    = ovf_reg;
endmodule

// File: tb/tb_fas_serial_ctrl.sv
// Directed bench for fas_serial_ctrl: arithmetic reference model plus per-cycle
// output comparison and hand-computed literal results.
module tb_fas_serial_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fas_serial_ctrl_if #(.N(N)) bus();

    fas_serial_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, result}
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic add, input logic cin);
        longint full, half, ua, ub, uc, sa, sb, t, sv;
        logic [N-1:0] r;
        logic co, ov;
        full = longint'(1) << N;
        half = longint'(1) << (N - 1);
        ua = longint'(a);
        ub = longint'(b);
        uc = longint'(cin);
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        if (add) begin
            t  = ua + ub + uc;
            co = (t >= full);
            sv = sa + sb + uc;
        end else begin
            t  = ua - ub - uc;
            co = (t < 0);
            if (t < 0) t = t + full;
            sv = sa - sb - uc;
        end
        r  = t[N-1:0];
        ov = (sv > half - 1) || (sv < -half);
        return {ov, co, r};
    endfunction

    // Timeline model: an accept happens when start is seen and no operation is in flight
    int           cyc    = 0;
    int           acc_c  = 0;
    bit           active = 1'b0;
    logic [N-1:0] pend_r = '0;
    logic         pend_co = 1'b0;
    logic         pend_ov = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  = 1'b0;
            pend_r  = '0;
            pend_co = 1'b0;
            pend_ov = 1'b0;
        end else begin
            cyc++;
            if (bus.start && (!active || cyc > acc_c + N)) begin
                active = 1'b1;
                acc_c  = cyc;
                {pend_ov, pend_co, pend_r} = model(bus.a_in, bus.b_in, bus.a_ns_in, bus.cin_in);
            end
        end
    end

    always @(negedge clk) begin
        bit in_run;
        bit dn;
        in_run = active && (cyc >= acc_c) && (cyc < acc_c + N);
        dn     = active && (cyc == acc_c + N);
        chk("cyc busy", bus.busy, in_run);
        chk("cyc done", bus.done, dn);
        if (!in_run) begin
            chk("cyc result", bus.result, pend_r);
            chk("cyc cout", bus.cout, pend_co);
            chk("cyc ovf", bus.ovf, pend_ov);
        end
    end

    task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic add, input logic cin, input logic [N-1:0] er,
                          input logic eco, input logic eov, input int glitch);
        int j;
        @(negedge clk);
        bus.a_in = a; bus.b_in = b; bus.a_ns_in = add; bus.cin_in = cin; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            if (j == glitch - 1) begin
                bus.start = 1'b1; bus.a_in = 8'hAA; bus.b_in = 8'h11; bus.a_ns_in = ~add;
            end
            if (j == glitch) bus.start = 1'b0;
            if (bus.done) break;
        end
        chk({nm, " latency"}, j, N);
        chk({nm, " result"}, bus.result, er);
        chk({nm, " cout"}, bus.cout, eco);
        chk({nm, " ovf"}, bus.ovf, eov);
        $display("op %s: a=%02h b=%02h add=%0d cin=%0d -> result=%02h cout=%0d ovf=%0d latency=%0d",
                 nm, a, b, add, cin, bus.result, bus.cout, bus.ovf, j);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d1, d2;
        logic [N-1:0] r1, r2;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.a_ns_in = 1'b0; bus.cin_in = 1'b0;
        #12;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset result", bus.result, 0);
        chk("reset cout", bus.cout, 0);
        chk("reset ovf", bus.ovf, 0);
        $display("reset: busy=%0d done=%0d result=%02h", bus.busy, bus.done, bus.result);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add35_4a", 8'h35, 8'h4A, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, -1);
        run_op("add7f_01", 8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, -1);
        run_op("addff_01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, -1);
        run_op("add00_cin", 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, -1);
        run_op("sub10_20", 8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, -1);
        run_op("sub80_01", 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, -1);
        run_op("sub05_cin", 8'h05, 8'h05, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, -1);
        run_op("ignored_start", 8'h35, 8'h4A, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 3);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        bus.a_in = 8'h35; bus.b_in = 8'h4A; bus.a_ns_in = 1'b1; bus.cin_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", bus.busy, 0);
        chk("midreset done", bus.done, 0);
        chk("midreset result", bus.result, 0);
        chk("midreset cout", bus.cout, 0);
        chk("midreset ovf", bus.ovf, 0);
        $display("midrun reset: busy=%0d done=%0d result=%02h", bus.busy, bus.done, bus.result);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op("after_reset", 8'h01, 8'h02, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, -1);

        // Back-to-back with start held high
        @(negedge clk);
        bus.a_in = 8'h01; bus.b_in = 8'h01; bus.a_ns_in = 1'b1; bus.cin_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a_in = 8'h03; bus.b_in = 8'h04;
        d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        for (int j = 0; j < 30; j++) begin
            if (j > 0) @(negedge clk);
            if (j == N + 1) bus.start = 1'b0;
            if (bus.done) begin
                if (d1 < 0) begin
                    d1 = j; r1 = bus.result;
                end else begin
                    d2 = j; r2 = bus.result;
                    break;
                end
            end
        end
        chk("b2b first latency", d1, N);
        chk("b2b spacing", d2 - d1, N + 1);
        chk("b2b first result", r1, 8'h02);
        chk("b2b second result", r2, 8'h07);
        $display("back-to-back: done at %0d and %0d, results %02h %02h", d1, d2, r1, r2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
